// File: rtl/scroll_ctrl_fsm_if.sv
// Control/status bundle for the scroll controller.
// Raw active-low keys go in; run state, position and step tick come out.
interface scroll_ctrl_fsm_if #(
    parameter int PW = 2
);
    logic          key_run;
    logic          key_dir;
    logic          key_step;
    logic          enable;
    logic          direction;
    logic [PW-1:0] pos;
    logic          tick;
    logic [1:0]    state;

    modport master (
        output key_run, key_dir, key_step,
        input  enable, direction, pos, tick, state
    );

    modport slave (
        input  key_run, key_dir, key_step,
        output enable, direction, pos, tick, state
    );
endinterface

// File: rtl/scroll_ctrl_fsm.sv
// Push-button conditioning, run/pause/step FSM and step-rate prescaler
// driving the scroll position of the 4-character display.
module scroll_ctrl_fsm #(
    parameter int STEP_CYCLES     = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int M               = 4,
    parameter int PW              = 2
) (
    input logic              CLOCK_50,
    input logic              aclr,
    scroll_ctrl_fsm_if.slave bus
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SW = $clog2(STEP_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(M - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    // Key index: 0 = run, 1 = dir, 2 = step
    logic [2:0]    raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    deb_q, deb_d;
    logic [2:0]    deb_prev_q;
    logic [2:0]    ev_q, ev_d;
    logic [DW-1:0] cnt_q [3];
    logic [DW-1:0] cnt_d [3];

    state_t        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [SW-1:0] presc_q, presc_d;
    logic          dir_q, dir_d;
    logic          tick_q, tick_d;
    logic          enable_q, enable_d;
    logic          advance;
    logic          run_ev, dir_ev, step_ev;

    function automatic logic [PW-1:0] next_pos(input logic [PW-1:0] p, input logic fwd);
        if (fwd) return (p == POS_LAST) ? '0 : p + 1'b1;
        else     return (p == '0) ? POS_LAST : p - 1'b1;
    endfunction

    assign raw     = {bus.key_step, bus.key_dir, bus.key_run};
    assign run_ev  = ev_q[0];
    assign dir_ev  = ev_q[1];
    assign step_ev = ev_q[2];

    // Debounce: the counter only runs while the synced key disagrees with the accepted level
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
                else                      cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        ev_d = deb_prev_q & ~deb_q;
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        presc_d = presc_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                pos_d   = '0;
                presc_d = '0;
                if (run_ev) state_d = RUN;
            end
            RUN: begin
                // A terminal-count step still happens when run pauses in the same cycle
                if (presc_q == STEP_LAST) begin
                    presc_d = '0;
                    advance = 1'b1;
                end else if (!run_ev) begin
                    presc_d = presc_q + 1'b1;
                end
                if (run_ev) state_d = PAUSE;
            end
            PAUSE: begin
                if (run_ev) begin
                    state_d = RUN;
                end else if (step_ev) begin
                    advance = 1'b1;
                    presc_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (advance) begin
            pos_d  = next_pos(pos_q, dir_q);
            tick_d = 1'b1;
        end
        if (dir_ev) dir_d = ~dir_q;
        enable_d = (state_d == RUN);
    end

    always_ff @(posedge CLOCK_50 or posedge aclr) begin
        if (aclr) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            deb_q      <= '1;
            deb_prev_q <= '1;
            ev_q       <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            state_q    <= IDLE;
            pos_q      <= '0;
            presc_q    <= '0;
            dir_q      <= 1'b1;
            tick_q     <= 1'b0;
            enable_q   <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            ev_q       <= ev_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            state_q    <= state_d;
            pos_q      <= pos_d;
            presc_q    <= presc_d;
            dir_q      <= dir_d;
            tick_q     <= tick_d;
            enable_q   <= enable_d;
        end
    end

    assign bus.enable    = enable_q;
    assign bus.direction = dir_q;
    assign bus.pos       = pos_q;
    assign bus.tick      = tick_q;
    assign bus.state     = state_q;
endmodule

// File: doc/scroll_ctrl_fsm.md
Name: scroll_ctrl_fsm

Overview:
- Upstream control stage for the 4-character scrolling display.
- Turns raw board push-buttons into clean run/pause/step/direction control and produces the scroll position index, one-step tick and enable level for the downstream mux/decoder stage.
- Owns the step-rate prescaler, so the downstream block no longer needs its own 1 s counter.

Parameters:
- STEP_CYCLES, 50000000: CLOCK_50 cycles per automatic step (1 s at 50 MHz); minimum 2.
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized cycles required to accept a key change (20 ms); minimum 1.
- M, 4: number of scroll positions; position wraps modulo M; minimum 2.
- PW, 2: width of pos output; must satisfy 2^PW >= M.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- aclr  in  1  asynchronous reset, active-high.
- key_run  in  1  raw run/pause button, active-low, asynchronous to clock.
- key_dir  in  1  raw direction-toggle button, active-low.
- key_step  in  1  raw single-step button, active-low.
- enable  out  1  high while in RUN.
- direction  out  1  1 = forward (pos increments), 0 = reverse (pos decrements).
- pos  out  PW  current scroll position, 0..M-1.
- tick  out  1  one-cycle pulse on every position change.
- state  out  2  FSM state for LEDs: IDLE=00, RUN=01, PAUSE=10; 11 never driven.

Behaviour:
- Reset (aclr high, asynchronous): state=IDLE, enable=0, direction=1, pos=0, tick=0, prescaler=0. Synchronizers and debounced levels are set to 1 (released). No press event is generated on reset release.
- Per key, input conditioning:
  - 2-FF synchronizer.
  - Debounce counter resets whenever the synced value equals the debounced level. The debounced level takes the synced value when the counter reaches DEBOUNCE_CYCLES-1.
  - The press event is a 1-cycle pulse on a debounced 1->0 transition.
  - Release generates nothing. A held key generates exactly one event.
  - A bounce shorter than DEBOUNCE_CYCLES is filtered out completely.
- Latency: a raw key held low from edge k produces its event pulse at edge k+DEBOUNCE_CYCLES+2. Registered outputs reflect the event at the next edge, k+DEBOUNCE_CYCLES+3.
- FSM:
  - IDLE: pos held at 0, prescaler 0. run event -> RUN. step event ignored.
  - RUN: prescaler counts 0..STEP_CYCLES-1.
    - At terminal count: prescaler returns to 0, pos advances, tick=1 for that cycle.
    - run event -> PAUSE; prescaler holds its value. step event ignored.
  - PAUSE: prescaler frozen.
    - run event -> RUN; prescaler resumes from the held value.
    - step event: pos advances once, tick=1, prescaler cleared to 0, state stays PAUSE.
- Position arithmetic:
  - Forward: pos = (pos == M-1) ? 0 : pos+1.
  - Reverse: pos = (pos == 0) ? M-1 : pos-1.
  - No out-of-range value is ever driven.
- Direction: a dir event toggles direction in any state, including IDLE. It takes effect on the next advance and does not touch the prescaler or pos.
- Simultaneous events:
  - RUN, run event in the same cycle as terminal count: the step is taken (tick, pos advance), then the FSM goes to PAUSE with prescaler 0.
  - PAUSE, run and step events in the same cycle: run wins and the step is dropped.
  - dir event in the same cycle as an advance: the advance uses the old direction; the toggle applies afterwards.
- enable = (state == RUN), registered with state.
- aclr asserted mid-operation aborts everything immediately to the reset values. In-progress debounce counts are discarded.

Test Plan:
(Bench parameters: STEP_CYCLES=8, DEBOUNCE_CYCLES=4, M=4, PW=2; key presses held 10 cycles unless stated.)
- Reset and start: release aclr, press key_run → state=01 and enable=1 exactly 7 edges after the key falls. Then tick every 8 cycles; pos sequence 1,2,3,0,1.
- Debounce: key_run low 3 cycles, high 2, low 3 → no event, state stays 00. Key held low 40 cycles → exactly one event.
- Pause, step and wrap:
  - RUN at pos=3 with prescaler=5, press run → PAUSE, prescaler stays 5.
  - Press step → pos=0 with a one-cycle tick, prescaler=0.
  - Press run → first tick 8 cycles later.
- Reverse: in RUN at pos=1, press key_dir → direction=0. Subsequent ticks give pos 0,3,2. Press key_dir again → direction=1.
- Simultaneous events:
  - Align a run event with terminal count → tick=1, pos advances, state=10, prescaler=0.
  - In PAUSE, run and step events in the same cycle → state=01, pos unchanged, no tick.
- Mid-operation reset: pulse aclr at pos=2 in RUN with key_step held low → all outputs return immediately to 0/IDLE with direction=1. No event after release until a fresh press.
